// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle main control FSM for the single-issue MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes a variable-latency data memory with a
// timeout, counts retired instructions and traps on illegal opcodes or memory timeout.
// Optional feature macro: MIPS_CTRL_JUMP_EN (makes opcode 000010 legal and adds Jump).
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Opcode,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
`ifdef MIPS_CTRL_JUMP_EN
    output logic             Jump,
`endif
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Last wait-count value that may still see mem_ready before the access times out.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic [7:0]       r_wait;
    logic             r_retire;
    logic [CNT_W-1:0] r_instret;
    logic             r_trap;
    logic [1:0]       r_cause;

    logic             w_legal;
    logic             w_is_r;
    logic             w_is_lw;
    logic             w_is_sw;
    logic             w_is_beq;
    logic             w_is_addi;
    logic             w_ir;
    logic             w_pc;
    logic             w_regwrite;
    logic             w_memread;
    logic             w_memwrite;
    logic             w_branch;
    logic             w_complete;
    logic             w_trap_set;
    logic [1:0]       w_trap_code;
    logic             w_sel_en;
    logic             w_regdst;
    logic             w_alusrc;
    logic             w_memtoreg;
    logic [1:0]       w_aluop;
`ifdef MIPS_CTRL_JUMP_EN
    logic             w_is_j;
    logic             w_jump;
`endif

    assign w_is_r    = (r_op == OP_RTYPE);
    assign w_is_lw   = (r_op == OP_LW);
    assign w_is_sw   = (r_op == OP_SW);
    assign w_is_beq  = (r_op == OP_BEQ);
    assign w_is_addi = (r_op == OP_ADDI);
`ifdef MIPS_CTRL_JUMP_EN
    assign w_is_j    = (r_op == OP_J);
`endif

    // Legality check of the incoming opcode, used while in DECODE.
    always_comb begin
        w_legal = 1'b0;
        case (Opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_legal = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
            OP_J:                                    w_legal = 1'b1;
`endif
            default:                                 w_legal = 1'b0;
        endcase
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        w_next      = r_state;
        w_ir        = 1'b0;
        w_pc        = 1'b0;
        w_regwrite  = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_branch    = 1'b0;
        w_complete  = 1'b0;
        w_trap_set  = 1'b0;
        w_trap_code = 2'b00;
`ifdef MIPS_CTRL_JUMP_EN
        w_jump      = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_ir   = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next      = S_TRAP;
                    w_trap_set  = 1'b1;
                    w_trap_code = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (w_is_beq) begin
                    w_branch   = 1'b1;
                    w_pc       = 1'b1;
                    w_complete = 1'b1;
                    w_next     = S_FETCH;
                end
`ifdef MIPS_CTRL_JUMP_EN
                else if (w_is_j) begin
                    w_jump     = 1'b1;
                    w_pc       = 1'b1;
                    w_complete = 1'b1;
                    w_next     = S_FETCH;
                end
`endif
                else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else if (w_is_r || w_is_addi) begin
                    w_next = S_WB;
                end else begin
                    w_next      = S_TRAP;
                    w_trap_set  = 1'b1;
                    w_trap_code = CAUSE_ILLEGAL;
                end
            end
            S_MEM: begin
                w_memread  = w_is_lw;
                w_memwrite = w_is_sw;
                if (mem_ready) begin
                    if (w_is_lw) begin
                        w_next = S_WB;
                    end else begin
                        w_pc       = 1'b1;
                        w_complete = 1'b1;
                        w_next     = S_FETCH;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_next      = S_TRAP;
                    w_trap_set  = 1'b1;
                    w_trap_code = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_pc       = 1'b1;
                w_complete = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next      = S_TRAP;
                w_trap_set  = 1'b1;
                w_trap_code = CAUSE_ILLEGAL;
            end
        endcase
    end

    // Datapath mux selects, derived from the latched opcode and held from EXEC to the end.
    always_comb begin
        w_sel_en   = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);
        w_regdst   = w_sel_en & w_is_r;
        w_alusrc   = w_sel_en & (w_is_lw | w_is_sw | w_is_addi);
        w_memtoreg = w_sel_en & w_is_lw;
        w_aluop    = 2'b00;
        if (w_sel_en) begin
            if (w_is_r) begin
                w_aluop = 2'b10;
            end else if (w_is_beq) begin
                w_aluop = 2'b01;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode latch, memory wait counter, retire pulse/counter and sticky trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_wait    <= '0;
            r_retire  <= 1'b0;
            r_instret <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            if (r_state == S_DECODE) begin
                r_op <= Opcode;
            end
            if ((r_state == S_MEM) && !mem_ready) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= '0;
            end
            r_retire <= w_complete;
            if (w_complete) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_trap_set) begin
                r_trap  <= 1'b1;
                r_cause <= w_trap_code;
            end
        end
    end

    // Control strobes are forced low while rst is held, so a reset cycle issues no writes.
    assign IRWrite    = w_ir       & ~rst;
    assign PCWrite    = w_pc       & ~rst;
    assign RegDst     = w_regdst   & ~rst;
    assign RegWrite   = w_regwrite & ~rst;
    assign ALUSrc     = w_alusrc   & ~rst;
    assign MemRead    = w_memread  & ~rst;
    assign MemWrite   = w_memwrite & ~rst;
    assign MemtoReg   = w_memtoreg & ~rst;
    assign Branch     = w_branch   & ~rst;
    assign ALUOp      = rst ? 2'b00 : w_aluop;
`ifdef MIPS_CTRL_JUMP_EN
    assign Jump       = w_jump     & ~rst;
`endif
    assign state      = r_state;
    assign retire     = r_retire;
    assign instret    = r_instret;
    assign trap       = r_trap;
    assign trap_cause = r_cause;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
`timescale 1ns/1ps
// tb_mips_multicycle_ctrl: expands each instruction into its expected cycle-by-cycle
// behaviour, drives it, and compares the DUT every cycle through an expectation queue.
module tb_mips_multicycle_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 32;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Control vector: {Jump, IRWrite, PCWrite, RegDst, RegWrite, ALUSrc,
    //                  MemRead, MemWrite, MemtoReg, Branch, ALUOp[1:0]}
    localparam logic [11:0] K_J  = 12'h800;
    localparam logic [11:0] K_IR = 12'h400;
    localparam logic [11:0] K_PC = 12'h200;
    localparam logic [11:0] K_RD = 12'h100;
    localparam logic [11:0] K_RW = 12'h080;
    localparam logic [11:0] K_AS = 12'h040;
    localparam logic [11:0] K_MR = 12'h020;
    localparam logic [11:0] K_MW = 12'h010;
    localparam logic [11:0] K_MT = 12'h008;
    localparam logic [11:0] K_BR = 12'h004;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    Opcode = '0;
    logic          mem_ready = 1'b0;
    logic          IRWrite, PCWrite, RegDst, RegWrite, ALUSrc;
    logic          MemRead, MemWrite, MemtoReg, Branch;
    logic [1:0]    ALUOp;
    logic [2:0]    state;
    logic          retire;
    logic [CW-1:0] instret;
    logic          trap;
    logic [1:0]    trap_cause;
    logic          jump_act;
`ifdef MIPS_CTRL_JUMP_EN
    logic          Jump;
    assign jump_act = Jump;
`else
    assign jump_act = 1'b0;
`endif

    mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .Branch(Branch), .ALUOp(ALUOp), .state(state), .retire(retire),
        .instret(instret), .trap(trap),
`ifdef MIPS_CTRL_JUMP_EN
        .Jump(Jump),
`endif
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         chk;
        logic [5:0] op;
        bit         rdy;
        logic [2:0] st;
        logic [11:0] ctl;
        bit         done;
        bit         trap;
        logic [1:0] cause;
    } cyc_t;

    typedef struct {
        bit          chk;
        logic [2:0]  st;
        logic [11:0] ctl;
        bit          retire;
        logic [CW-1:0] instret;
        bit          trap;
        logic [1:0]  cause;
    } exp_t;

    cyc_t stim_q[$];
    exp_t exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic bit rnd1();
        return 1'($urandom);
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        if (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI) return 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
        if (op == OP_J) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic cyc_t mk(input bit r, input bit chk, input logic [5:0] op, input bit rdy,
                                input logic [2:0] st, input logic [11:0] ctl, input bit done,
                                input bit tr, input logic [1:0] cause);
        cyc_t c;
        c.rst = r; c.chk = chk; c.op = op; c.rdy = rdy; c.st = st; c.ctl = ctl;
        c.done = done; c.trap = tr; c.cause = cause;
        return c;
    endfunction

    // Two reset cycles: the second one is observed after a reset edge.
    task automatic gen_reset();
        stim_q.push_back(mk(1'b1, 1'b0, rnd6(), rnd1(), 3'd0, 12'h000, 1'b0, 1'b0, 2'b00));
        stim_q.push_back(mk(1'b1, 1'b1, rnd6(), rnd1(), 3'd0, 12'h000, 1'b0, 1'b0, 2'b00));
    endtask

    // One instruction: d = mem_ready-low cycles before ready; cut truncates for a mid-flight reset.
    task automatic gen_instr(input logic [5:0] op, input int unsigned d, input int trap_len, input int cut);
        cyc_t q[$];
        logic [11:0] sel;
        logic [11:0] mm;
        bit is_lw, is_sw, trapped;
        int keep;
        trapped = 1'b0;
        sel     = '0;
        is_lw   = (op == OP_LW);
        is_sw   = (op == OP_SW);
        q.push_back(mk(1'b0, 1'b1, rnd6(), rnd1(), 3'd0, K_IR, 1'b0, 1'b0, 2'b00));
        q.push_back(mk(1'b0, 1'b1, op, rnd1(), 3'd1, 12'h000, 1'b0, 1'b0, 2'b00));
        if (!is_legal(op)) begin
            trapped = 1'b1;
            for (int i = 0; i < trap_len; i++)
                q.push_back(mk(1'b0, 1'b1, rnd6(), rnd1(), 3'd5, 12'h000, 1'b0, 1'b1, 2'b01));
        end else begin
            if (op == OP_R) begin sel = sel | K_RD; sel[1:0] = 2'b10; end
            if (is_lw || is_sw || op == OP_ADDI) sel = sel | K_AS;
            if (is_lw) sel = sel | K_MT;
            if (op == OP_BEQ) sel[1:0] = 2'b01;
            if (op == OP_BEQ) begin
                q.push_back(mk(1'b0, 1'b1, op, rnd1(), 3'd2, sel | K_BR | K_PC, 1'b1, 1'b0, 2'b00));
            end else if (op == OP_J) begin
                q.push_back(mk(1'b0, 1'b1, op, rnd1(), 3'd2, sel | K_J | K_PC, 1'b1, 1'b0, 2'b00));
            end else if (is_lw || is_sw) begin
                mm = is_lw ? K_MR : K_MW;
                q.push_back(mk(1'b0, 1'b1, op, rnd1(), 3'd2, sel, 1'b0, 1'b0, 2'b00));
                for (int unsigned c = 0; c <= d; c++) begin
                    if (c == d) begin
                        if (is_lw) begin
                            q.push_back(mk(1'b0, 1'b1, op, 1'b1, 3'd3, sel | mm, 1'b0, 1'b0, 2'b00));
                            q.push_back(mk(1'b0, 1'b1, op, rnd1(), 3'd4, sel | K_RW | K_PC, 1'b1, 1'b0, 2'b00));
                        end else begin
                            q.push_back(mk(1'b0, 1'b1, op, 1'b1, 3'd3, sel | mm | K_PC, 1'b1, 1'b0, 2'b00));
                        end
                    end else begin
                        q.push_back(mk(1'b0, 1'b1, op, 1'b0, 3'd3, sel | mm, 1'b0, 1'b0, 2'b00));
                        if (c == T - 1) begin
                            trapped = 1'b1;
                            for (int i = 0; i < trap_len; i++)
                                q.push_back(mk(1'b0, 1'b1, rnd6(), rnd1(), 3'd5, 12'h000, 1'b0, 1'b1, 2'b10));
                            break;
                        end
                    end
                end
            end else begin
                q.push_back(mk(1'b0, 1'b1, op, rnd1(), 3'd2, sel, 1'b0, 1'b0, 2'b00));
                q.push_back(mk(1'b0, 1'b1, op, rnd1(), 3'd4, sel | K_RW | K_PC, 1'b1, 1'b0, 2'b00));
            end
        end
        keep = (cut < q.size()) ? cut : q.size();
        for (int i = 0; i < keep; i++) stim_q.push_back(q[i]);
        if (trapped || keep < q.size()) gen_reset();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // Driver: applies one cycle of stimulus after each rising edge and queues its expectation.
    initial begin : driver
        cyc_t r;
        exp_t e;
        bit prev_done;
        logic [CW-1:0] cnt;
        logic [5:0] op;
        prev_done = 1'b0;
        cnt       = '0;

        gen_reset();
        gen_instr(OP_R,    0, 0, 99);
        gen_instr(OP_LW,   3, 0, 99);
        gen_instr(OP_SW,   0, 0, 99);
        gen_instr(OP_BEQ,  0, 0, 99);
        gen_instr(6'b111111, 0, 20, 99);
        gen_instr(OP_LW,   T + 3, 5, 99);
        gen_instr(OP_LW,   T - 1, 0, 99);
        gen_instr(OP_SW,   T - 1, 0, 99);
        gen_instr(OP_SW,   T + 1, 3, 99);
        gen_instr(OP_ADDI, 0, 0, 99);
        gen_instr(OP_J,    0, 4, 99);
        gen_instr(OP_LW,   2, 0, 4);
        gen_instr(OP_R,    0, 0, 99);
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 6))
                0:       op = OP_R;
                1:       op = OP_LW;
                2:       op = OP_SW;
                3:       op = OP_BEQ;
                4:       op = OP_ADDI;
                5:       op = OP_J;
                default: op = rnd6();
            endcase
            gen_instr(op, $urandom_range(0, T + 1), int'($urandom_range(1, 6)),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 4)) : 99);
        end

        while (stim_q.size() > 0) begin
            @(posedge clk);
            #1;
            r = stim_q.pop_front();
            rst       = r.rst;
            Opcode    = r.op;
            mem_ready = r.rdy;
            e.chk   = r.chk;
            e.st    = r.st;
            e.ctl   = r.ctl;
            e.trap  = r.trap;
            e.cause = r.cause;
            e.retire = prev_done;
            if (prev_done) cnt = cnt + 1;
            e.instret = cnt;
            if (r.rst) begin
                prev_done = 1'b0;
                cnt       = '0;
            end else begin
                prev_done = r.done;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Monitor: pops the expectation for the current cycle and compares on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [11:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                n_vec++;
                act = {jump_act, IRWrite, PCWrite, RegDst, RegWrite, ALUSrc,
                       MemRead, MemWrite, MemtoReg, Branch, ALUOp};
                check("state",      32'(state),      32'(e.st));
                check("ctl",        32'(act),        32'(e.ctl));
                check("retire",     32'(retire),     32'(e.retire));
                check("instret",    32'(instret),    32'(e.instret));
                check("trap",       32'(trap),       32'(e.trap));
                check("trap_cause", 32'(trap_cause), 32'(e.cause));
            end
        end
    end

endmodule
